// File: rtl/hack_pkg.sv
// Shared constants for the Hack ALU pipeline: default width, ctrl bit
// positions and the named comp codes used by decode and test code.
package hack_pkg;

  localparam int WIDTH = 16;

  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  typedef logic [5:0] comp_t;

  localparam comp_t ZERO    = 6'b101010;
  localparam comp_t ONE     = 6'b111111;
  localparam comp_t NEG1    = 6'b111010;
  localparam comp_t X       = 6'b001100;
  localparam comp_t Y       = 6'b110000;
  localparam comp_t NOTX    = 6'b001101;
  localparam comp_t XPLUSY  = 6'b000010;
  localparam comp_t XMINUSY = 6'b010011;
  localparam comp_t XANDY   = 6'b000000;
  localparam comp_t XORY    = 6'b010101;

endpackage

// File: rtl/hack_alu_preset.sv
// Operand conditioning for one ALU input: optional zeroing followed by
// optional bitwise negation through the inverter datapath.
module hack_alu_preset #(
  parameter int WIDTH = hack_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_zero,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_zeroed;
  logic [WIDTH-1:0] w_inverted;

  assign w_zeroed   = i_zero ? '0 : i_data;
  assign w_inverted = ~w_zeroed;
  assign o_data     = i_neg ? w_inverted : w_zeroed;

endmodule

// File: rtl/hack_alu_pipe.sv
// Two-stage Hack ALU with valid/ready flow control: stage 1 registers the
// conditioned operands, stage 2 registers the result and its flags.
module hack_alu_pipe
  import hack_pkg::*;
#(
  parameter int WIDTH = hack_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] w_x_pre;
  logic [WIDTH-1:0] w_y_pre;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_out;
  logic             w_s1_load;
  logic             w_s2_load;

  logic             r_v1;
  logic [WIDTH-1:0] r_x1;
  logic [WIDTH-1:0] r_y1;
  logic             r_f1;
  logic             r_no1;

  logic             r_v2;
  logic [WIDTH-1:0] r_out2;
  logic             r_zr2;
  logic             r_ng2;

  hack_alu_preset #(.WIDTH(WIDTH)) u_preset_x (
    .i_data (x),
    .i_zero (ctrl[CTRL_ZX]),
    .i_neg  (ctrl[CTRL_NX]),
    .o_data (w_x_pre)
  );

  hack_alu_preset #(.WIDTH(WIDTH)) u_preset_y (
    .i_data (y),
    .i_zero (ctrl[CTRL_ZY]),
    .i_neg  (ctrl[CTRL_NY]),
    .o_data (w_y_pre)
  );

  // Ready depends only on valid bits and out_ready, so no in_valid->in_ready path.
  assign w_s2_load = !r_v2 || out_ready;
  assign w_s1_load = !r_v1 || w_s2_load;
  assign in_ready  = w_s1_load;

  // Carry out of the adder is intentionally dropped.
  assign w_sum = r_x1 + r_y1;
  assign w_res = r_f1 ? w_sum : (r_x1 & r_y1);
  assign w_out = r_no1 ? ~w_res : w_res;

  // NOTE: state registers use non-blocking assignments so both stages sample
  // the pre-edge values of each other and shift together on one edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_v1  <= 1'b0;
      r_x1  <= '0;
      r_y1  <= '0;
      r_f1  <= 1'b0;
      r_no1 <= 1'b0;
    end else if (w_s1_load) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_x1  <= w_x_pre;
        r_y1  <= w_y_pre;
        r_f1  <= ctrl[CTRL_F];
        r_no1 <= ctrl[CTRL_NO];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_v2   <= 1'b0;
      r_out2 <= '0;
      r_zr2  <= 1'b0;
      r_ng2  <= 1'b0;
    end else if (w_s2_load) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_out2 <= w_out;
        r_zr2  <= (w_out == '0);
        r_ng2  <= w_out[WIDTH-1];
      end
    end
  end

  assign out_valid = r_v2;
  assign out       = r_out2;
  assign zr        = r_zr2;
  assign ng        = r_ng2;

endmodule
